// File: rtl/mdu_pkg.sv
// Shared types and helpers for the Multiply-Division Unit controllers.
// The divider controllers reuse this package as well.
package mdu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } mult_state_t;

    // Counter must reach width-1, so one extra bit is always enough.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/csa_seq_multiplier_csa.sv
// Bitwise 3:2 carry-save adder. The carry vector is NOT shifted here;
// callers apply the <<1 weighting when they consume it.
module carrySaveAdder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] addendA,
    input  logic [WIDTH-1:0] addendB,
    input  logic [WIDTH-1:0] addendC,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry
);

    // Per-bit full adder: xor for sum, majority for carry.
    always_comb begin
        sum   = addendA ^ addendB ^ addendC;
        carry = (addendA & addendB) | (addendA & addendC) | (addendB & addendC);
    end

endmodule

// File: rtl/csa_seq_multiplier.sv
// Sequential unsigned multiplier: one partial product per cycle into a
// redundant sum/carry accumulator, then a single carry-propagate resolve.
module csa_seq_multiplier
    import mdu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    output logic                 ready_o,
    input  logic [WIDTH-1:0]     op_a_i,
    input  logic [WIDTH-1:0]     op_b_i,
    output logic                 busy_o,
    output logic                 result_valid_o,
    input  logic                 result_ack_i,
    output logic [2*WIDTH-1:0]   result_o
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    mult_state_t       state_r;
    mult_state_t       stateNext_s;
    logic [PW-1:0]     aShift_r;
    logic [WIDTH-1:0]  bShift_r;
    logic [PW-1:0]     sum_r;
    logic [PW-1:0]     carry_r;
    logic [CW-1:0]     cnt_r;
    logic [PW-1:0]     result_r;

    logic [PW-1:0]     pp_s;
    logic [PW-1:0]     carryFb_s;
    logic [PW-1:0]     csaSum_s;
    logic [PW-1:0]     csaCarry_s;

    // Partial product selection and weighted carry feedback (MSB dropped).
    always_comb begin
        pp_s      = {PW{1'b0}};
        carryFb_s = {carry_r[PW-2:0], 1'b0};
        if (bShift_r[0]) begin
            pp_s = aShift_r;
        end else begin
            pp_s = {PW{1'b0}};
        end
    end

    carrySaveAdder #(
        .WIDTH(PW)
    ) u_csa (
        .addendA(sum_r),
        .addendB(carryFb_s),
        .addendC(pp_s),
        .sum    (csaSum_s),
        .carry  (csaCarry_s)
    );

    // Next-state decode; unknown encodings fall back to IDLE.
    always_comb begin
        stateNext_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    stateNext_s = ACCUM;
                end else begin
                    stateNext_s = IDLE;
                end
            end
            ACCUM: begin
                if (cnt_r == LAST_CNT) begin
                    stateNext_s = RESOLVE;
                end else begin
                    stateNext_s = ACCUM;
                end
            end
            RESOLVE: begin
                stateNext_s = DONE;
            end
            DONE: begin
                if (result_ack_i) begin
                    stateNext_s = IDLE;
                end else begin
                    stateNext_s = DONE;
                end
            end
            default: begin
                stateNext_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= stateNext_s;
        end
    end

    // Datapath: operand capture, accumulate/shift, and final resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aShift_r <= {PW{1'b0}};
            bShift_r <= {WIDTH{1'b0}};
            sum_r    <= {PW{1'b0}};
            carry_r  <= {PW{1'b0}};
            cnt_r    <= {CW{1'b0}};
            result_r <= {PW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_i) begin
                        aShift_r <= {{WIDTH{1'b0}}, op_a_i};
                        bShift_r <= op_b_i;
                        sum_r    <= {PW{1'b0}};
                        carry_r  <= {PW{1'b0}};
                        cnt_r    <= {CW{1'b0}};
                    end
                end
                ACCUM: begin
                    sum_r    <= csaSum_s;
                    carry_r  <= csaCarry_s;
                    aShift_r <= {aShift_r[PW-2:0], 1'b0};
                    bShift_r <= {1'b0, bShift_r[WIDTH-1:1]};
                    cnt_r    <= cnt_r + CW'(1);
                end
                RESOLVE: begin
                    // The true product always fits in PW bits, so wrap is lossless.
                    result_r <= sum_r + carryFb_s;
                end
                DONE: begin
                    result_r <= result_r;
                end
                default: begin
                    result_r <= result_r;
                end
            endcase
        end
    end

    assign ready_o        = (state_r == IDLE);
    assign busy_o         = (state_r == ACCUM) || (state_r == RESOLVE);
    assign result_valid_o = (state_r == DONE);
    assign result_o       = result_r;

endmodule

// File: tb/tb_csa_seq_multiplier.sv
// Self-checking bench for csa_seq_multiplier (WIDTH=4) with a product scoreboard.
module tb_csa_seq_multiplier;

    logic       clk;
    logic       rst_n;
    logic       start_i;
    logic       ready_o;
    logic [3:0] op_a_i;
    logic [3:0] op_b_i;
    logic       busy_o;
    logic       result_valid_o;
    logic       result_ack_i;
    logic [7:0] result_o;

    int checks = 0;
    int errors = 0;
    int episodes = 0;
    logic prevValid = 1'b0;
    logic [7:0] expQ[$];

    csa_seq_multiplier #(.WIDTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .ready_o       (ready_o),
        .op_a_i        (op_a_i),
        .op_b_i        (op_b_i),
        .busy_o        (busy_o),
        .result_valid_o(result_valid_o),
        .result_ack_i  (result_ack_i),
        .result_o      (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: compare the product at the start of every valid episode.
    always @(negedge clk) begin
        if (result_valid_o && !prevValid) begin
            episodes++;
            if (expQ.size() == 0) begin
                checkVal("unexpected_valid", 16'd1, 16'd0);
            end else begin
                checkVal("sb_product", {8'd0, result_o}, {8'd0, expQ.pop_front()});
            end
        end
        prevValid = result_valid_o;
    end

    function automatic logic [7:0] mul(input logic [3:0] a, input logic [3:0] b);
        return {4'd0, a} * {4'd0, b};
    endfunction

    // Called one delta after a rising edge with the DUT idle.
    task automatic doOp(input logic [3:0] a, input logic [3:0] b, input int hold,
                        input bit inject, input bit startInDone);
        logic [7:0] exp;
        exp = mul(a, b);
        checkVal("ready_before", {15'd0, ready_o}, 16'd1);
        start_i = 1'b1; op_a_i = a; op_b_i = b;
        @(posedge clk);
        expQ.push_back(exp);
        #1;
        start_i = 1'b0;
        op_a_i = 4'($urandom); op_b_i = 4'($urandom);
        checkVal("ready_after_accept", {15'd0, ready_o}, 16'd0);
        checkVal("busy_after_accept", {15'd0, busy_o}, 16'd1);
        for (int e = 1; e <= 4; e++) begin
            if (inject && e == 2) begin
                start_i = 1'b1; op_a_i = 4'd2; op_b_i = 4'd2;
            end
            if (hold == 0 && e == 4) result_ack_i = 1'b1;
            @(posedge clk);
            #1;
            start_i = 1'b0;
            checkVal("busy_accum", {15'd0, busy_o}, 16'd1);
            checkVal("valid_early", {15'd0, result_valid_o}, 16'd0);
        end
        @(posedge clk);
        #1;
        checkVal("valid_done", {15'd0, result_valid_o}, 16'd1);
        checkVal("busy_done", {15'd0, busy_o}, 16'd0);
        checkVal("result_done", {8'd0, result_o}, {8'd0, exp});
        for (int h = 1; h < hold; h++) begin
            @(posedge clk);
            #1;
            checkVal("valid_held", {15'd0, result_valid_o}, 16'd1);
        end
        result_ack_i = 1'b1;
        if (startInDone) begin
            start_i = 1'b1; op_a_i = 4'd1; op_b_i = 4'd1;
        end
        @(posedge clk);
        #1;
        result_ack_i = 1'b0;
        start_i = 1'b0;
        checkVal("valid_after_ack", {15'd0, result_valid_o}, 16'd0);
        checkVal("ready_after_ack", {15'd0, ready_o}, 16'd1);
        @(posedge clk);
        #1;
        checkVal("still_idle", {15'd0, ready_o}, 16'd1);
        checkVal("result_hold_idle", {8'd0, result_o}, {8'd0, exp});
    endtask

    initial begin
        int accepts;
        int cyc;
        int acceptCyc[2];
        logic rdy;

        rst_n = 1'b0; start_i = 1'b0; op_a_i = 4'd0; op_b_i = 4'd0; result_ack_i = 1'b0;
        #12;
        checkVal("rst_result", {8'd0, result_o}, 16'd0);
        checkVal("rst_valid", {15'd0, result_valid_o}, 16'd0);
        checkVal("rst_busy", {15'd0, busy_o}, 16'd0);
        checkVal("rst_ready", {15'd0, ready_o}, 16'd1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        doOp(4'd3, 4'd5, 0, 1'b0, 1'b0);
        doOp(4'd15, 4'd15, 1, 1'b0, 1'b0);
        doOp(4'd8, 4'd9, 2, 1'b0, 1'b1);
        doOp(4'd0, 4'd9, 3, 1'b0, 1'b0);
        doOp(4'd9, 4'd0, 3, 1'b0, 1'b0);
        doOp(4'd6, 4'd7, 1, 1'b1, 1'b0);

        // Reset mid-operation: the accepted 13 x 11 must vanish.
        start_i = 1'b1; op_a_i = 4'd13; op_b_i = 4'd11;
        @(posedge clk);
        expQ.push_back(mul(4'd13, 4'd11));
        #1 start_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        expQ.delete();
        checkVal("abort_result", {8'd0, result_o}, 16'd0);
        checkVal("abort_valid", {15'd0, result_valid_o}, 16'd0);
        checkVal("abort_busy", {15'd0, busy_o}, 16'd0);
        checkVal("abort_ready", {15'd0, ready_o}, 16'd1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        doOp(4'd6, 4'd7, 1, 1'b0, 1'b0);

        // Back-to-back with ack tied high and start held high.
        result_ack_i = 1'b1; start_i = 1'b1; op_a_i = 4'd2; op_b_i = 4'd3;
        accepts = 0; cyc = 0;
        while (accepts < 2 && cyc < 40) begin
            @(negedge clk);
            rdy = ready_o;
            @(posedge clk);
            cyc++;
            if (rdy) begin
                expQ.push_back(mul(op_a_i, op_b_i));
                acceptCyc[accepts] = cyc;
                accepts++;
                #1;
                op_a_i = 4'd4; op_b_i = 4'd4;
                if (accepts == 2) start_i = 1'b0;
            end
        end
        start_i = 1'b0;
        checkVal("b2b_accepts", 16'(accepts), 16'd2);
        if (accepts == 2) checkVal("b2b_spacing", 16'(acceptCyc[1] - acceptCyc[0]), 16'd7);
        repeat (8) @(posedge clk);
        #1;
        result_ack_i = 1'b0;
        checkVal("b2b_idle", {15'd0, ready_o}, 16'd1);
        checkVal("b2b_last_result", {8'd0, result_o}, 16'h0010);

        @(negedge clk);
        checkVal("sb_drained", 16'(expQ.size()), 16'd0);
        checkVal("episode_count", 16'(episodes), 16'd9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
